// File: rtl/paint_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : paint_scheduler
// Purpose  : Queues decoded SPI position updates and paints each one as a
//            1-pixel or 3x3 brush stamp, clipped to the screen, issuing one
//            framebuffer write per pixel over a valid/ready handshake.
// Options  : define DRAW_CLEAR_EN to add the clearReq port and a full-screen
//            clear state that fills the framebuffer with CLEAR_COLOR.
// Revision : 1.0 - initial release
// ============================================================================
module paint_scheduler #(
  parameter int         WIDTH       = 160,
  parameter int         HEIGHT      = 120,
  parameter int         ADDR_W      = 15,
  parameter int         FIFO_DEPTH  = 4,
`ifdef DRAW_CLEAR_EN
  parameter logic [2:0] CLEAR_COLOR = 3'b000,
`endif
  parameter logic [2:0] RESET_COLOR = 3'b010   // green
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              updateConfig,
  input  logic              updatePosition,
  input  logic              brush,
  input  logic [2:0]        newColor,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
`ifdef DRAW_CLEAR_EN
  input  logic              clearReq,
`endif
  output logic              fbWe,
  output logic [ADDR_W-1:0] fbAddr,
  output logic [2:0]        fbData,
  input  logic              fbReady,
  output logic              busy,
  output logic              dropped
);

  localparam int         c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_paint = 2'd2;
`ifdef DRAW_CLEAR_EN
  localparam logic [1:0]        c_st_clear = 2'd3;
  localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(WIDTH * HEIGHT - 1);
`endif

  logic [1:0]       r_state, w_next;
  logic             r_cfg_q, r_pos_q, r_brush, r_dropped;
  logic [2:0]       r_color;
  // queue entry layout: {x[7:0], y[7:0], brush, color[2:0]}
  logic [19:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wptr, r_rptr;
  logic [c_aw:0]    r_count;
  logic [7:0]       r_x, r_y;
  logic             r_eb;
  logic [2:0]       r_ec;
  logic [1:0]       r_ox, r_oy;       // offset index 0..2, i.e. dx/dy + 1
  logic             w_cfg_rise, w_pos_rise, w_full, w_pop, w_push, w_clr_go;
  logic             w_in_brush;
  logic [2:0]       w_in_color;
  logic [8:0]       w_nx, w_ny;
  logic             w_inb, w_last, w_adv, w_center_off;
  logic [ADDR_W-1:0] w_addr;
`ifdef DRAW_CLEAR_EN
  logic              r_clr_q, r_clr_pend;
  logic [ADDR_W-1:0] r_clr_addr;
  assign w_clr_go = r_clr_pend;
`else
  assign w_clr_go = 1'b0;
`endif

  // Strobe edges; a simultaneous config edge feeds the pushed entry directly.
  assign w_cfg_rise = updateConfig & ~r_cfg_q;
  assign w_pos_rise = updatePosition & ~r_pos_q;
  assign w_in_brush = w_cfg_rise ? brush : r_brush;
  assign w_in_color = w_cfg_rise ? newColor : r_color;
  assign w_full     = (r_count == (c_aw+1)'(FIFO_DEPTH));
  assign w_pop      = (r_state == c_st_idle) && (r_count != '0) && !w_clr_go;
  assign w_push     = w_pos_rise && (!w_full || w_pop);

  // Current stamp pixel: signed offset math, clipping and address.
  assign w_nx         = {1'b0, r_x} + {7'd0, r_ox} - 9'd1;
  assign w_ny         = {1'b0, r_y} + {7'd0, r_oy} - 9'd1;
  assign w_inb        = !w_nx[8] && (w_nx < 9'(WIDTH)) && !w_ny[8] && (w_ny < 9'(HEIGHT));
  assign w_addr       = ADDR_W'(w_ny) * ADDR_W'(WIDTH) + ADDR_W'(w_nx);
  assign w_last       = !r_eb || ((r_ox == 2'd2) && (r_oy == 2'd2));
  assign w_adv        = !w_inb || fbReady;
  assign w_center_off = ({1'b0, r_x} >= 9'(WIDTH)) || ({1'b0, r_y} >= 9'(HEIGHT));

  // Edge history, config registers, queue pointers and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_q   <= 1'b0;
      r_pos_q   <= 1'b0;
      r_brush   <= 1'b0;
      r_color   <= RESET_COLOR;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_cfg_q   <= updateConfig;
      r_pos_q   <= updatePosition;
      r_dropped <= w_pos_rise && w_full && !w_pop;
      if (w_cfg_rise) begin
        r_brush <= brush;
        r_color <= newColor;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; attributes are frozen at push time.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {x, y, w_in_brush, w_in_color};
  end

  // Stamp datapath: popped entry, offset walk and clear address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_eb <= 1'b0;
      r_ec <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else begin
      if (w_pop) {r_x, r_y, r_eb, r_ec} <= r_mem[r_rptr];
      if (r_state == c_st_load) begin
        r_ox <= r_eb ? 2'd0 : 2'd1;
        r_oy <= r_eb ? 2'd0 : 2'd1;
      end else if ((r_state == c_st_paint) && w_adv) begin
        if (r_ox == 2'd2) begin
          r_ox <= 2'd0;
          r_oy <= r_oy + 2'd1;
        end else begin
          r_ox <= r_ox + 2'd1;
        end
      end
    end
  end

`ifdef DRAW_CLEAR_EN
  // Clear request latch and fill address; a new edge outranks consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_q    <= 1'b0;
      r_clr_pend <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      r_clr_q <= clearReq;
      if (clearReq && !r_clr_q)      r_clr_pend <= 1'b1;
      else if (r_state == c_st_idle) r_clr_pend <= 1'b0;
      if (r_state == c_st_idle)                    r_clr_addr <= '0;
      else if ((r_state == c_st_clear) && fbReady) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
`ifdef DRAW_CLEAR_EN
        if (w_clr_go)             w_next = c_st_clear;
        else if (r_count != '0)   w_next = c_st_load;
`else
        if (r_count != '0)        w_next = c_st_load;
`endif
      end
      c_st_load:  w_next = w_center_off ? c_st_idle : c_st_paint;
      c_st_paint: if (w_adv && w_last) w_next = c_st_idle;
`ifdef DRAW_CLEAR_EN
      c_st_clear: if (fbReady && (r_clr_addr == c_clr_last)) w_next = c_st_idle;
`endif
      default:    w_next = c_st_idle;
    endcase
  end

  // Outputs: write request held from registered state until accepted.
  always_comb begin
    fbWe   = 1'b0;
    fbAddr = '0;
    fbData = '0;
    if ((r_state == c_st_paint) && w_inb) begin
      fbWe   = 1'b1;
      fbAddr = w_addr;
      fbData = r_ec;
    end
`ifdef DRAW_CLEAR_EN
    if (r_state == c_st_clear) begin
      fbWe   = 1'b1;
      fbAddr = r_clr_addr;
      fbData = CLEAR_COLOR;
    end
`endif
    busy    = (r_state != c_st_idle) || (r_count != '0) || w_clr_go;
    dropped = r_dropped;
  end

endmodule
`default_nettype wire

// File: tb/tb_paint_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_paint_scheduler
// Purpose  : Directed self-checking bench for paint_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paint_scheduler;

  logic        clk = 1'b0;
  logic        reset, updateConfig, updatePosition, brush, fbReady;
  logic [2:0]  newColor;
  logic [7:0]  x, y;
  logic        fbWe, busy, dropped;
  logic [14:0] fbAddr;
  logic [2:0]  fbData;
`ifdef DRAW_CLEAR_EN
  logic        clearReq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr [9];
  int k, nexp, nbad;

  always #5 clk = ~clk;

  paint_scheduler dut (
    .clk(clk), .reset(reset), .updateConfig(updateConfig),
    .updatePosition(updatePosition), .brush(brush), .newColor(newColor),
    .x(x), .y(y),
`ifdef DRAW_CLEAR_EN
    .clearReq(clearReq),
`endif
    .fbWe(fbWe), .fbAddr(fbAddr), .fbData(fbData), .fbReady(fbReady),
    .busy(busy), .dropped(dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic b, input logic [2:0] c);
    brush = b; newColor = c; updateConfig = 1'b1;
    tick();
    updateConfig = 1'b0;
    tick();
  endtask

  // Returns one cycle after the push edge, strobe already low again.
  task automatic push(input logic [7:0] px, input logic [7:0] py);
    x = px; y = py; updatePosition = 1'b1;
    tick();
    updatePosition = 1'b0;
  endtask

  task automatic wait_we(input string tag, input int limit);
    for (int i = 0; i < limit && fbWe !== 1'b1; i++) tick();
    check(tag, fbWe, 1);
  endtask

  // fbReady=1: check fbWe/addr on each of the 9 PAINT cycles, then idle.
  task automatic stamp_cycles(input string tag, input logic [7:0] px, input logic [7:0] py,
                              input logic [8:0] mask);
    int j = 0;
    push(px, py);
    tick();
    tick();
    for (int c = 0; c < 9; c++) begin
      check({tag, "_we"}, fbWe, mask[c]);
      if (mask[c]) begin
        check({tag, "_addr"}, fbAddr, exp_addr[j]);
        j++;
      end
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; updateConfig = 1'b0; updatePosition = 1'b0; brush = 1'b0;
    newColor = 3'd0; x = 8'd0; y = 8'd0; fbReady = 1'b1;
`ifdef DRAW_CLEAR_EN
    clearReq = 1'b0;
`endif
    repeat (3) tick();
    check("rst_we", fbWe, 0);
    check("rst_addr", fbAddr, 0);
    check("rst_data", fbData, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    reset = 1'b0;
    tick();

    // 1px stamp at (10,5): addr 810, 2-cycle latency, idle 3 cycles after push
    cfg(1'b0, 3'b100);
    push(8'd10, 8'd5);
    check("t1_busy", busy, 1);
    check("t1_we_c1", fbWe, 0);
    tick();
    check("t1_we_c2", fbWe, 0);
    tick();
    check("t1_we", fbWe, 1);
    check("t1_addr", fbAddr, 810);
    check("t1_data", fbData, 3'b100);
    tick();
    check("t1_we_done", fbWe, 0);
    check("t1_busy_done", busy, 0);

    // 3x3 interior stamp at (50,61) with fbReady alternating 0/1
    cfg(1'b1, 3'b011);
    fbReady = 1'b0;
    exp_addr = '{9649, 9650, 9651, 9809, 9810, 9811, 9969, 9970, 9971};
    push(8'd50, 8'd61);
    for (int i = 0; i < 9; i++) begin
      wait_we("t2_we", 10);
      check("t2_addr", fbAddr, exp_addr[i]);
      check("t2_data", fbData, 3'b011);
      tick();
      check("t2_hold_we", fbWe, 1);
      check("t2_hold_addr", fbAddr, exp_addr[i]);
      check("t2_hold_data", fbData, 3'b011);
      fbReady = 1'b1;
      tick();
      fbReady = 1'b0;
    end
    check("t2_busy_end", busy, 0);

    // clipped corners with fbReady tied high
    fbReady = 1'b1;
    exp_addr = '{0, 1, 160, 161, 0, 0, 0, 0, 0};
    stamp_cycles("t3_c00", 8'd0, 8'd0, 9'b110110000);
    exp_addr = '{19038, 19039, 19198, 19199, 0, 0, 0, 0, 0};
    stamp_cycles("t3_c159", 8'd159, 8'd119, 9'b000011011);

    // off-screen center: no writes, back to idle
    push(8'd200, 8'd3);
    check("t4_we0", fbWe, 0);
    tick();
    check("t4_we1", fbWe, 0);
    check("t4_busy1", busy, 1);
    tick();
    check("t4_we2", fbWe, 0);
    check("t4_busy2", busy, 0);

    // queue overflow while a stamp is stalled
    cfg(1'b0, 3'b101);
    fbReady = 1'b0;
    push(8'd1, 8'd1);
    tick();
    tick();
    check("t5_stall_we", fbWe, 1);
    check("t5_stall_addr", fbAddr, 161);
    for (int i = 0; i < 5; i++) begin
      x = 8'(2 + i); y = 8'd0; updatePosition = 1'b1;
      tick();
      check("t5_dropped_edge", dropped, (i == 4) ? 1 : 0);
      updatePosition = 1'b0;
      tick();
      check("t5_dropped_after", dropped, 0);
    end
    exp_addr = '{161, 2, 3, 4, 5, 0, 0, 0, 0};
    fbReady = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (fbWe === 1'b1) begin
        if (k < 5) begin
          check("t5_order_addr", fbAddr, exp_addr[k]);
          check("t5_order_data", fbData, 3'b101);
        end
        k++;
      end
      tick();
    end
    check("t5_write_count", k, 5);
    check("t5_busy_end", busy, 0);

    // config change after push keeps old color
    cfg(1'b0, 3'b001);
    push(8'd20, 8'd2);
    newColor = 3'b110; updateConfig = 1'b1;
    tick();
    updateConfig = 1'b0;
    tick();
    check("t6_we", fbWe, 1);
    check("t6_addr", fbAddr, 340);
    check("t6_data", fbData, 3'b001);
    tick();

    // config and position edges in the same cycle: new color applies
    brush = 1'b0; newColor = 3'b111; x = 8'd30; y = 8'd0;
    updateConfig = 1'b1; updatePosition = 1'b1;
    tick();
    updateConfig = 1'b0; updatePosition = 1'b0;
    tick();
    tick();
    check("t6b_we", fbWe, 1);
    check("t6b_addr", fbAddr, 30);
    check("t6b_data", fbData, 3'b111);
    tick();

    // reset in the middle of a stalled stamp with a point queued
    cfg(1'b1, 3'b010);
    fbReady = 1'b0;
    push(8'd50, 8'd50);
    tick();
    push(8'd60, 8'd60);
    check("t7_we_before", fbWe, 1);
    check("t7_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("t7_we_reset", fbWe, 0);
    check("t7_busy_reset", busy, 0);
    reset = 1'b0;
    fbReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t7_no_write", fbWe, 0);
    end

    // strobe held high through reset release counts as one edge
    reset = 1'b1; updatePosition = 1'b1; x = 8'd10; y = 8'd5;
    tick();
    reset = 1'b0;
    tick();
    check("t8_busy", busy, 1);
    tick();
    tick();
    check("t8_we", fbWe, 1);
    check("t8_addr", fbAddr, 810);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t8_single_edge", busy, 0);
      tick();
    end
    updatePosition = 1'b0;
    tick();

`ifdef DRAW_CLEAR_EN
    // clear requested together with a queued point: clear first, then point
    fbReady = 1'b1; clearReq = 1'b1; x = 8'd7; y = 8'd0; updatePosition = 1'b1;
    tick();
    clearReq = 1'b0; updatePosition = 1'b0;
    check("t9_busy", busy, 1);
    nexp = 0; nbad = 0;
    for (int i = 0; i < 19300 && nexp < 19200; i++) begin
      if (fbWe === 1'b1) begin
        if (fbAddr !== 15'(nexp) || fbData !== 3'b000) nbad++;
        nexp++;
      end
      tick();
    end
    check("t9_clear_count", nexp, 19200);
    check("t9_clear_bad", nbad, 0);
    wait_we("t9_point_we", 10);
    check("t9_point_addr", fbAddr, 7);
    tick();
    check("t9_busy_end", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
